// File: rtl/drum_mul_arbiter_if.sv
// drum_mul_arbiter_if: requester/response bus of the shared DRUM multiplier arbiter.
// DRUM_ARB_EXACT_EN adds the per-requester req_exact select.
interface drum_mul_arbiter_if #(
   parameter int N_IN    = 16,
   parameter int M_IN    = 16,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*N_IN-1:0] req_a;
   logic [NUM_REQ*M_IN-1:0] req_b;
`ifdef DRUM_ARB_EXACT_EN
   logic [NUM_REQ-1:0]      req_exact;
`endif
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [N_IN+M_IN-1:0]    rsp_r;
   logic                    busy;

   modport master (
`ifdef DRUM_ARB_EXACT_EN
      output req_exact,
`endif
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_r, busy
   );

   modport slave (
`ifdef DRUM_ARB_EXACT_EN
      input  req_exact,
`endif
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_r, busy
   );
endinterface

// File: rtl/drum_mul_arbiter.sv
// drum_mul_arbiter: round-robin arbiter sharing one two-stage DRUM approximate multiplier.
// Define DRUM_ARB_EXACT_EN to add req_exact, selecting the exact product per operation.
module drum_mul_arbiter #(
   parameter int K_IN    = 6,
   parameter int N_IN    = 16,
   parameter int M_IN    = 16,
   parameter int NUM_REQ = 4
) (
   input logic clk,
   input logic rst,
   drum_mul_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int W    = N_IN > M_IN ? N_IN : M_IN;
   localparam int SH_W = $clog2(W);
   localparam int P_W  = N_IN + M_IN;
   localparam logic [SH_W-1:0] KM1 = SH_W'(K_IN - 1);

   logic [ID_W-1:0]    prio, win, s1_id, s2_id;
   logic [ID_W:0]      idx;
   logic               found, s1_v, s2_v, s2_free, s1_take, hs;
   logic [NUM_REQ-1:0] ready;
   logic [N_IN-1:0]    sel_a, s1_a;
   logic [M_IN-1:0]    sel_b, s1_b;
   logic [P_W-1:0]     drum_p, prod, s2_r;
`ifdef DRUM_ARB_EXACT_EN
   logic               sel_x, s1_x;
`endif

   function automatic logic [SH_W-1:0] lead_one(input logic [W-1:0] x);
      lead_one = '0;
      for (int i = 0; i < W; i++)
         if (x[i]) lead_one = SH_W'(i);
   endfunction

   function automatic logic [SH_W-1:0] drum_sh(input logic [W-1:0] x);
      logic [SH_W-1:0] k;
      k = lead_one(x);
      return k > KM1 ? k - KM1 : '0;
   endfunction

   // Shifting the leading one down to bit K_IN-1 keeps the next K_IN-2 bits; bit 0 is forced high.
   function automatic logic [K_IN-1:0] drum_val(input logic [W-1:0] x);
      logic [W-1:0] t;
      t = x >> drum_sh(x);
      return {t[K_IN-1:1], t[0] | (lead_one(x) > KM1)};
   endfunction

   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int o = NUM_REQ - 1; o >= 0; o--) begin
         idx = {1'b0, prio} + (ID_W+1)'(o);
         idx = idx >= (ID_W+1)'(NUM_REQ) ? idx - (ID_W+1)'(NUM_REQ) : idx;
         if (bus.req_valid[idx[ID_W-1:0]]) begin
            win   = idx[ID_W-1:0];
            found = 1'b1;
         end
      end
      sel_a = '0;
      sel_b = '0;
`ifdef DRUM_ARB_EXACT_EN
      sel_x = 1'b0;
`endif
      for (int i = 0; i < NUM_REQ; i++)
         if (win == ID_W'(i)) begin
            sel_a = bus.req_a[i*N_IN +: N_IN];
            sel_b = bus.req_b[i*M_IN +: M_IN];
`ifdef DRUM_ARB_EXACT_EN
            sel_x = bus.req_exact[i];
`endif
         end
      s2_free = !s2_v || bus.rsp_ready;
      s1_take = !rst && (!s1_v || s2_free);
      ready   = (found && s1_take) ? NUM_REQ'(1) << win : '0;
      hs      = |(ready & bus.req_valid);
   end

   always_comb begin
      drum_p = (P_W'(drum_val(W'(s1_a))) * P_W'(drum_val(W'(s1_b))))
               << ({1'b0, drum_sh(W'(s1_a))} + {1'b0, drum_sh(W'(s1_b))});
`ifdef DRUM_ARB_EXACT_EN
      prod = s1_x ? P_W'(s1_a) * P_W'(s1_b) : drum_p;
`else
      prod = drum_p;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio  <= '0;
         s1_v  <= 1'b0;
         s2_v  <= 1'b0;
         s2_r  <= '0;
         s2_id <= '0;
      end else begin
         if (hs) prio <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         if (s2_free) begin
            s2_v <= s1_v;
            if (s1_v) begin
               s2_r  <= prod;
               s2_id <= s1_id;
            end
         end
         if (s1_take) s1_v <= hs;
         if (hs) begin
            s1_a  <= sel_a;
            s1_b  <= sel_b;
            s1_id <= win;
`ifdef DRUM_ARB_EXACT_EN
            s1_x  <= sel_x;
`endif
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = s2_v;
   assign bus.rsp_r     = s2_r;
   assign bus.rsp_id    = s2_id;
   assign bus.busy      = s1_v | s2_v;
endmodule

// File: tb/tb_drum_mul_arbiter.sv
// tb_drum_mul_arbiter: directed vectors plus round-robin, backpressure and reset sequences.
module tb_drum_mul_arbiter;
   localparam int NR = 4, N = 16, M = 16;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   drum_mul_arbiter_if #(.N_IN(N), .M_IN(M), .NUM_REQ(NR)) bus ();
   drum_mul_arbiter #(.K_IN(6), .N_IN(N), .M_IN(M), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   typedef struct {
      int          id;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   vec_t vec[10];
   int   n_chk = 0, n_fail = 0, hs_cnt, rsp_cnt;
   int   exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
      bus.req_a[id*N +: N] = a;
      bus.req_b[id*M +: M] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic run_one(input vec_t v);
      bus.req_valid = '0;
      set_ops(v.id, v.a, v.b);
      bus.req_valid[v.id] = 1'b1;
      #1 chk("vec_ready", bus.req_ready, NR'(1) << v.id);
      tick();
      bus.req_valid = '0;
      set_ops(v.id, ~v.a, ~v.b);
      #1 chk("vec_latency", bus.rsp_valid, 0);
      tick();
      #1 chk("vec_valid", bus.rsp_valid, 1);
      chk("vec_r", bus.rsp_r, v.p);
      chk("vec_id", bus.rsp_id, v.id);
      tick();
      #1 chk("vec_drained", bus.busy, 0);
   endtask

   initial begin
      vec[0] = '{1, 16'd3, 16'd5, 32'd15};
      vec[1] = '{0, 16'd1000, 16'd3, 32'd3024};
      vec[2] = '{2, 16'd0, 16'd65535, 32'd0};
      vec[3] = '{3, 16'd65535, 16'd65535, 32'hF8100000};
      vec[4] = '{0, 16'd31, 16'd31, 32'd961};
      vec[5] = '{1, 16'd32, 16'd63, 32'd2016};
      vec[6] = '{2, 16'd64, 16'd1, 32'd66};
      vec[7] = '{3, 16'd100, 16'd100, 32'd10404};
      vec[8] = '{0, 16'd1, 16'd1, 32'd1};
      vec[9] = '{1, 16'd12345, 16'd0, 32'd0};

      bus.req_valid = '1;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b1;
`ifdef DRUM_ARB_EXACT_EN
      bus.req_exact = '0;
`endif
      rst = 1'b1;
      tick();
      tick();
      #1 chk("rst_ready", bus.req_ready, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_r", bus.rsp_r, 0);
      chk("rst_id", bus.rsp_id, 0);
      bus.req_valid = '0;
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) run_one(vec[i]);
`ifdef DRUM_ARB_EXACT_EN
      bus.req_exact[0] = 1'b1;
      run_one('{0, 16'd1000, 16'd3, 32'd3000});
      bus.req_exact = '0;
`endif

      // round robin with all requesters held valid from reset release
      for (int i = 0; i < NR; i++) set_ops(i, 16'(i + 1), 16'd2);
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         #1 chk("rr_grant", bus.req_ready, NR'(1) << (k % NR));
         chk("rr_valid", bus.rsp_valid, k >= 2);
         if (k >= 2) begin
            chk("rr_id", bus.rsp_id, (k - 2) % NR);
            chk("rr_r", bus.rsp_r, 2 * ((k - 2) % NR + 1));
         end
         tick();
      end

      // backpressure: pipeline fills two deep then stalls
      bus.rsp_ready = 1'b0;
      do_reset();
      hs_cnt = 0;
      for (int k = 0; k < 7; k++) begin
         #1 hs_cnt += int'(|(bus.req_valid & bus.req_ready));
         if (k >= 2) begin
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_r", bus.rsp_r, 2);
         end
         tick();
      end
      chk("bp_accepted", hs_cnt, 2);
      exp_q = {0, 1};
      rsp_cnt = 0;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) bus.req_valid = '0;
         #1;
         for (int i = 0; i < NR; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) exp_q.push_back(i);
         if (bus.rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) chk("bp_dup", 1, 0);
            else begin
               chk("bp_order_id", bus.rsp_id, exp_q[0]);
               chk("bp_order_r", bus.rsp_r, 2 * (exp_q[0] + 1));
               void'(exp_q.pop_front());
            end
         end
         tick();
      end
      chk("bp_count", rsp_cnt, 5);
      chk("bp_idle", bus.busy, 0);

      // reset with both stages full
      bus.req_valid = '1;
      bus.rsp_ready = 1'b0;
      do_reset();
      tick();
      tick();
      #1 chk("mr_full_busy", bus.busy, 1);
      chk("mr_full_valid", bus.rsp_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 chk("mr_valid", bus.rsp_valid, 0);
      chk("mr_busy", bus.busy, 0);
      chk("mr_grant", bus.req_ready, 4'b0001);
      bus.rsp_ready = 1'b1;
      tick();
      tick();
      #1 chk("mr_first_valid", bus.rsp_valid, 1);
      chk("mr_first_id", bus.rsp_id, 0);
      bus.req_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/drum_mul_arbiter.md
DRUM_MUL_ARBITER -- requirements
Module: drum_mul_arbiter

Interface
REQ-001 Parameter K_IN, default 6: DRUM truncation width; keep K_IN >= 3 and K_IN <= min(N_IN, M_IN).
REQ-002 Parameter N_IN, default 16: operand A width.
REQ-003 Parameter M_IN, default 16: operand B width.
REQ-004 Parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester operand-valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 req_a  in  NUM_REQ*N_IN  packed operand A; requester i uses slice [i*N_IN +: N_IN].
REQ-010 req_b  in  NUM_REQ*M_IN  packed operand B; requester i uses slice [i*M_IN +: M_IN].
REQ-011 rsp_valid  out  1  result-valid.
REQ-012 rsp_ready  in  1  downstream accept.
REQ-013 rsp_id  out  clog2(NUM_REQ)  index of the requester that owns rsp_r.
REQ-014 rsp_r  out  N_IN+M_IN  approximate product.
REQ-015 busy  out  1  high while either pipeline stage holds valid data.

Function
REQ-016 The block arbitrates one shared DRUM multiplier between requesters, using a two-stage pipeline: S1 holds operands and id; S2 holds product and id.
REQ-017 Arbitration is round-robin. Priority starts at the requester after the last grant and searches upward with wrap-around. The pointer advances only on an accepted handshake.
REQ-018 A handshake occurs when req_valid[i] and req_ready[i] are both high. req_ready[i] is high only for the current winner, and only when S1 is empty or S1 advances in the same cycle.
REQ-019 S1 advances into S2 when S2 is empty, or when S2 is emptied in the same cycle (rsp_valid & rsp_ready).
REQ-020 The product is computed combinationally from the S1 operands and registered into S2:
- leading-one position k of each operand;
- if k > K_IN-1, use {1, bits [k-1 -: K_IN-2], 1} with shift k-(K_IN-1);
- otherwise use the low K_IN bits with shift 0;
- multiply the two K_IN-bit values and shift left by the sum of the shifts.
REQ-021 A zero operand yields rsp_r = 0.
REQ-022 Latency is 2 cycles: a handshake at edge T gives rsp_valid at edge T+2 when there is no backpressure.
REQ-023 Sustained throughput is one result per cycle while rsp_ready = 1.
REQ-024 While rsp_valid = 1 and rsp_ready = 0, rsp_r and rsp_id hold stable. The pipeline fills at most 2 deep, after which all req_ready bits are 0.
REQ-025 Requester operands are sampled only at the handshake; later changes have no effect on an accepted operation.
REQ-026 A requester dropping req_valid without a handshake is legal and causes no grant.
REQ-027 busy = S1 valid | S2 valid.

Reset
REQ-028 On rst, at the next rising edge:
- S1 and S2 valids clear;
- the round-robin pointer resets so that requester 0 has highest priority;
- rsp_valid = 0, rsp_r = 0, rsp_id = 0, busy = 0, req_ready = 0.
REQ-029 Reset mid-operation discards in-flight operations without producing a response.
REQ-030 The first grant after reset release occurs no earlier than the first edge at which rst is low.

Configuration
REQ-031 Macro DRUM_ARB_EXACT_EN:
- When defined, add input req_exact (NUM_REQ bits). It is captured into S1 at the handshake. A captured 1 makes S2 load the exact product a*b; a captured 0 makes S2 load the DRUM product.
- When undefined, the port does not exist and every result is the DRUM product.

Verification
REQ-032 Requester 1 sends a=3, b=5, rsp_ready=1 -> rsp_valid two cycles later, rsp_r=15, rsp_id=1.
REQ-033 Requester 0 sends a=1000, b=3 -> rsp_r=3024. With DRUM_ARB_EXACT_EN defined and req_exact[0]=1 -> rsp_r=3000.
REQ-034 All four requesters hold req_valid from reset release, rsp_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; rsp_id follows the same order, one result per cycle.
REQ-035 rsp_ready=0 for 5 cycles with continuous requests -> exactly 2 operations accepted; rsp_r/rsp_id stable; req_ready=0 until rsp_ready rises; no result lost or duplicated.
REQ-036 rst asserted for one cycle while both stages are valid -> next cycle rsp_valid=0, busy=0; the next grant goes to requester 0.
REQ-037 Requester 2 sends a=0, b=65535 -> rsp_r=0.
